// File: rtl/wb_stage_pkg.sv
// Shared types and encodings for the write-back stage.
// Load funct3 codes follow the RV64 load opcode encoding.
package wb_stage_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_LD = 1'b1
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load aligner: selects the addressed lane of the doubleword and extends it,
// flagging misaligned accesses and unsupported funct3 codes.
module wb_load_align
    import wb_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [2:0]      addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data,
    output logic            misaligned,
    output logic            illegal
);

    logic [XLEN-1:0] lane;

    assign lane = rdata >> {addr, 3'b000};

    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_LBU: data = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_LH: begin
                data       = {{(XLEN-16){lane[15]}}, lane[15:0]};
                misaligned = addr[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, lane[15:0]};
                misaligned = addr[0];
            end
            F3_LW: begin
                data       = {{(XLEN-32){lane[31]}}, lane[31:0]};
                misaligned = |addr[1:0];
            end
            F3_LWU: begin
                data       = {{(XLEN-32){1'b0}}, lane[31:0]};
                misaligned = |addr[1:0];
            end
            F3_LD: begin
                data       = lane;
                misaligned = |addr;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle into the register file, waiting for
// load data when required and reporting misaligned/illegal loads, timeouts and stray rvalids.
//
//   state      | meaning
//   ST_IDLE    | accepting from MEM; ALU results and faulted loads retire next cycle
//   ST_WAIT_LD | load issued, waiting for dmem_rvalid or timeout
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int AW         = 6,
    parameter int LD_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_rd,
    input  logic            mem_rd_wen,
    input  logic            mem_is_load,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_result,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [AW-1:0]   wdata_addr,
    output logic [XLEN-1:0] wdata,
    output logic            wdata_ena,
    output logic            retire,
    output logic            wb_err
);

    localparam int CW = $clog2(LD_TIMEOUT + 1);

    wb_state_e       state_q, state_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [AW-1:0]   ld_rd_q, ld_rd_nxt;
    logic            ld_wen_q, ld_wen_nxt;
    logic [2:0]      ld_f3_q, ld_f3_nxt;
    logic [2:0]      ld_addr_q, ld_addr_nxt;

    logic            ready_q;
    logic [AW-1:0]   waddr_q, waddr_nxt;
    logic [XLEN-1:0] wdata_q, wdata_nxt;
    logic            ena_q, ena_nxt;
    logic            retire_q, retire_nxt;
    logic            err_q, err_nxt;

    logic [2:0]      al_f3, al_addr;
    logic [XLEN-1:0] al_data;
    logic            al_misaligned, al_illegal;
    logic            xfer;

    // The aligner checks the incoming load in IDLE and extends the latched one in WAIT_LD.
    assign al_f3   = (state_q == ST_IDLE) ? mem_funct3 : ld_f3_q;
    assign al_addr = (state_q == ST_IDLE) ? mem_result[2:0] : ld_addr_q;

    wb_load_align #(.XLEN(XLEN)) u_align (
        .funct3     (al_f3),
        .addr       (al_addr),
        .rdata      (dmem_rdata),
        .data       (al_data),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    assign xfer = mem_valid && ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_wen_q  <= 1'b0;
            ld_f3_q   <= '0;
            ld_addr_q <= '0;
            ready_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            ena_q     <= 1'b0;
            retire_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            ld_rd_q   <= ld_rd_nxt;
            ld_wen_q  <= ld_wen_nxt;
            ld_f3_q   <= ld_f3_nxt;
            ld_addr_q <= ld_addr_nxt;
            ready_q   <= (state_nxt == ST_IDLE);
            waddr_q   <= waddr_nxt;
            wdata_q   <= wdata_nxt;
            ena_q     <= ena_nxt;
            retire_q  <= retire_nxt;
            err_q     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        ld_rd_nxt   = ld_rd_q;
        ld_wen_nxt  = ld_wen_q;
        ld_f3_nxt   = ld_f3_q;
        ld_addr_nxt = ld_addr_q;
        waddr_nxt   = waddr_q;
        wdata_nxt   = wdata_q;
        ena_nxt     = 1'b0;
        retire_nxt  = 1'b0;
        err_nxt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_nxt = dmem_rvalid;
                if (xfer) begin
                    if (!mem_is_load) begin
                        retire_nxt = 1'b1;
                        if (mem_rd_wen && (mem_rd != '0)) begin
                            ena_nxt   = 1'b1;
                            waddr_nxt = mem_rd;
                            wdata_nxt = mem_result;
                        end
                    end else if (al_misaligned || al_illegal) begin
                        retire_nxt = 1'b1;
                        err_nxt    = 1'b1;
                    end else begin
                        ld_rd_nxt   = mem_rd;
                        ld_wen_nxt  = mem_rd_wen;
                        ld_f3_nxt   = mem_funct3;
                        ld_addr_nxt = mem_result[2:0];
                        cnt_nxt     = '0;
                        state_nxt   = ST_WAIT_LD;
                    end
                end
            end
            ST_WAIT_LD: begin
                cnt_nxt = cnt_q + 1'b1;
                // rvalid on the limit cycle still completes the load
                if (dmem_rvalid) begin
                    retire_nxt = 1'b1;
                    state_nxt  = ST_IDLE;
                    if (ld_wen_q && (ld_rd_q != '0)) begin
                        ena_nxt   = 1'b1;
                        waddr_nxt = ld_rd_q;
                        wdata_nxt = al_data;
                    end
                end else if (cnt_q == CW'(LD_TIMEOUT)) begin
                    retire_nxt = 1'b1;
                    err_nxt    = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mem_ready  = ready_q;
    assign wdata_addr = waddr_q;
    assign wdata      = wdata_q;
    assign wdata_ena  = ena_q;
    assign retire     = retire_q;
    assign wb_err     = err_q;

endmodule
